// File: rtl/vt_pkg.sv
// Shared FSM state encoding and default geometry for the Wishbone burst master.
package vt_pkg;

    localparam int VT_ADDR_WIDTH     = 32;
    localparam int VT_DATA_WIDTH     = 32;
    localparam int VT_LEN_WIDTH      = 8;
    localparam int VT_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_BUS   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } vt_state_e;

endpackage

// File: rtl/vt_wb_timeout.sv
// Saturating strobe-wait counter; expire flags the increment that would reach LIMIT.
module vt_wb_timeout #(
    parameter int LIMIT = 255,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [W-1:0] count;

    // Combinational so the master can abort on the very edge the limit is hit.
    assign expire = inc && (count == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vt_wb_master.sv
// Command-driven Wishbone classic burst master: one strobe per beat, cyc held
// across the burst, per-beat ack timeout that aborts the rest of the burst.
module vt_wb_master
    import vt_pkg::*;
#(
    parameter int ADDR_WIDTH     = VT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = VT_DATA_WIDTH,
    parameter int LEN_WIDTH      = VT_LEN_WIDTH,
    parameter int TIMEOUT_CYCLES = VT_TIMEOUT_CYCLES
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                    wbm_ack_i,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int SEL_W = DATA_WIDTH / 8;

    vt_state_e            state;
    logic [LEN_WIDTH-1:0] beats_left;
    logic                 cmd_fire, wr_fire;
    logic                 tmo_clr, tmo_inc, tmo_expire;

    assign cmd_fire = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign wr_fire  = (state == ST_WDATA) && wr_valid && wr_ready;

    // Counter restarts on every edge that moves the FSM into BUS.
    assign tmo_clr = (cmd_fire && !cmd_we && (cmd_len != '0)) || wr_fire || (state == ST_GAP);
    assign tmo_inc = (state == ST_BUS) && !wbm_ack_i;

    vt_wb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            beats_left <= '0;
            cmd_ready  <= 1'b0;
            wr_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        wbm_we_o   <= cmd_we;
                        wbm_adr_o  <= cmd_adr;
                        wbm_sel_o  <= cmd_sel;
                        beats_left <= cmd_len;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (cmd_len == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (cmd_we) begin
                            wr_ready <= 1'b1;
                            state    <= ST_WDATA;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            state     <= ST_BUS;
                        end
                    end
                end
                ST_WDATA: begin
                    if (wr_fire) begin
                        wbm_dat_o <= wr_data;
                        wr_ready  <= 1'b0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i) begin
                        wbm_stb_o  <= 1'b0;
                        wbm_adr_o  <= wbm_adr_o + ADDR_WIDTH'(SEL_W);
                        beats_left <= beats_left - 1'b1;
                        if (!wbm_we_o) begin
                            rd_data  <= wbm_dat_i;
                            rd_valid <= 1'b1;
                        end
                        if (beats_left == LEN_WIDTH'(1)) begin
                            wbm_cyc_o <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else if (wbm_we_o) begin
                            wr_ready <= 1'b1;
                            state    <= ST_WDATA;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else if (tmo_expire) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        beats_left <= '0;
                        done       <= 1'b1;
                        err        <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    wbm_stb_o <= 1'b1;
                    state     <= ST_BUS;
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vt_wb_master.md
VT_WB_MASTER -- requirements
Module: vt_wb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: Wishbone data width; sel width is DATA_WIDTH/8.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: beat-count width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles stb may wait for ack.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have wb_rst_i  in  1  asynchronous, active-high reset.
REQ-008 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_adr in ADDR_WIDTH, cmd_sel in DATA_WIDTH/8, cmd_len in LEN_WIDTH: command port; beats = cmd_len.
REQ-009 SHALL have wr_valid in 1, wr_ready out 1, wr_data in DATA_WIDTH: write-data port, one word per beat.
REQ-010 SHALL have rd_valid out 1, rd_data out DATA_WIDTH: read-data port, no backpressure.
REQ-011 SHALL have wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out DATA_WIDTH/8; wbm_adr_o out ADDR_WIDTH; wbm_dat_o out DATA_WIDTH; wbm_dat_i in DATA_WIDTH; wbm_ack_i in 1: Wishbone classic master.
REQ-012 SHALL have busy out 1, done out 1, err out 1: status; done/err are one-cycle pulses.

Function
REQ-013 SHALL implement FSM states IDLE, WDATA, BUS, GAP, DONE; all outputs registered.
REQ-014 IDLE: cmd_ready=1, busy=0; on cmd_valid, latch we/adr/sel/len; len=0 -> DONE (no bus cycle); else we=1 -> WDATA, we=0 -> BUS.
REQ-015 WDATA: wr_ready=1, cyc held if beats already issued, stb=0; on wr_valid, latch wr_data into wbm_dat_o -> BUS.
REQ-016 BUS: cyc=stb=1, we/sel/adr/dat driven from latched values; a write first reaches the bus the cycle after the wr_valid handshake, a read the cycle after cmd acceptance.
REQ-017 On wbm_ack_i in BUS: stb drops next cycle; address += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH); remaining beats decrement; last beat -> DONE, else write -> WDATA, read -> GAP.
REQ-018 GAP: cyc=1, stb=0 for exactly one cycle -> BUS.
REQ-019 Read ack SHALL register wbm_dat_i into rd_data and pulse rd_valid for one cycle in the cycle following the ack.
REQ-020 wbm_cyc_o SHALL stay high from the first BUS entry until the DONE transition; it SHALL never be high in IDLE or DONE.
REQ-021 Timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack; reaching TIMEOUT_CYCLES -> drop cyc/stb, abort remaining beats -> DONE with err.
REQ-022 Ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success (ack wins).
REQ-023 DONE: one cycle; done=1, err=1 only if timed out; then -> IDLE; cmd_ready=0 during DONE.
REQ-024 busy=1 in every state except IDLE.
REQ-025 cmd_valid while busy SHALL be ignored (cmd_ready=0); wr_valid outside WDATA SHALL be ignored.
REQ-026 wbm_ack_i outside BUS SHALL be ignored.

Reset
REQ-027 Asserting wb_rst_i SHALL immediately force state IDLE; cyc, stb, we, rd_valid, done, err, busy, wr_ready = 0; adr, sel, dat_o, rd_data, counters = 0; cmd_ready = 0 while reset is asserted, 1 from the first edge after release.
REQ-028 Reset mid-transfer SHALL drop cyc/stb asynchronously with no done/err pulse.

Structure
REQ-029 Shared package vt_pkg SHALL hold the FSM state enum and the default width/timeout constants.
REQ-030 One sub-module is natural: vt_wb_timeout (loadable saturating counter with an expiry flag).

Verification
REQ-031 Single read: cmd adr=0x3000_0000, len=1, we=0; ack after 2 cycles with dat_i=0xDEADBEEF -> rd_valid one cycle, rd_data=0xDEADBEEF, done pulse, cyc low afterwards.
REQ-032 Write burst: adr=0x3000_0010, len=3, sel=0xF, data 0x11,0x22,0x33 -> three acked strobes at 0x..10/0x..14/0x..18, stb low between beats, cyc continuous, one done.
REQ-033 Timeout: read len=2, never ack, TIMEOUT_CYCLES=8 -> cyc/stb drop after 8 stb cycles, done=1 and err=1 same cycle, no rd_valid.
REQ-034 Ack on the expiry cycle -> beat succeeds, err=0.
REQ-035 Reset asserted during the second beat of a 4-beat read -> cyc/stb low in the same cycle, no done, next command accepted normally.
REQ-036 len=0 and address wrap: len=0 -> done without cyc; read at adr=0xFFFF_FFFC, len=2 -> second beat at 0x0000_0000.
